preamble_generator: RTL

- Transmit-side counterpart of the CSI receive chain; emits one 802.11a/g legacy training preamble per trigger as a 20 MSPS complex AXI-Stream.
- Preamble is 10 short training symbol (STS) periods (160 samples), then the long training sequence (LTS) section: GI2 plus 2 LTS (160 samples). Total 320 samples per frame.
- Feeds the DAC/upsampler path. Gives the receive chain a known stimulus for loopback and channel-sounding measurements.

---
 rtl/preamble_pkg.sv | 47 ++++
 rtl/preamble_generator_if.sv | 12 +
 rtl/preamble_rom.sv | 25 ++
 rtl/preamble_generator.sv | 159 +++++++++++++++
 4 files changed

// File: rtl/preamble_pkg.sv
// rtl/preamble_pkg.sv - shared types, section lengths and training-sequence tables
package preamble_pkg;

   typedef enum logic [2:0] {IDLE, PRE, STS, LTS, GAP} state_t;

   localparam int STS_LEN    = 160;
   localparam int LTS_LEN    = 160;
   localparam int STS_PERIOD = 16;
   localparam int LTS_PERIOD = 64;
   localparam int GI2_LEN    = 32;

   // Table entries are in thousandths of full scale; x128 gives ~4x gain into Q1.15.
   function automatic logic [31:0] iq(input int i_milli, input int q_milli);
      return {16'(i_milli * 128), 16'(q_milli * 128)};
   endfunction

   function automatic logic [15:0] asr16(input logic [15:0] v, input int unsigned sh);
      return 16'($signed(v) >>> sh);
   endfunction

   localparam logic [31:0] sts_rom [STS_PERIOD] = '{
      iq(  46,   46), iq(-132,    2), iq( -13,  -79), iq( 143,  -13),
      iq(  92,    0), iq( 143,  -13), iq( -13,  -79), iq(-132,    2),
      iq(  46,   46), iq(   2, -132), iq( -79,  -13), iq( -13,  143),
      iq(   0,   92), iq( -13,  143), iq( -79,  -13), iq(   2, -132)
   };

   localparam logic [31:0] lts_rom [LTS_PERIOD] = '{
      iq( 156,    0), iq(  -5, -120), iq(  40, -111), iq(  97,   83),
      iq(  21,   28), iq(  60,  -88), iq(-115,  -55), iq( -38, -106),
      iq(  98,  -26), iq(  53,    4), iq(   1, -115), iq(-137,  -47),
      iq(  24,  -59), iq(  59,  -15), iq( -22,  161), iq( 119,   -4),
      iq(  62,  -62), iq(  37,   98), iq( -57,   39), iq(-131,   65),
      iq(  82,   92), iq(  70,   14), iq( -60,   81), iq( -56,  -22),
      iq( -35, -151), iq(-122,  -17), iq(-127,  -21), iq(  75,  -74),
      iq(  -3,   54), iq( -92,  115), iq(  92,  106), iq(  12,   98),
      iq(-156,    0), iq(  12,  -98), iq(  92, -106), iq( -92, -115),
      iq(  -3,  -54), iq(  75,   74), iq(-127,   21), iq(-122,   17),
      iq( -35,  151), iq( -56,   22), iq( -60,  -81), iq(  70,  -14),
      iq(  82,  -92), iq(-131,  -65), iq( -57,  -39), iq(  37,  -98),
      iq(  62,   62), iq( 119,    4), iq( -22, -161), iq(  59,   15),
      iq(  24,   59), iq(-137,   47), iq(   1,  115), iq(  53,   -4),
      iq(  98,   26), iq( -38,  106), iq(-115,   55), iq(  60,   88),
      iq(  21,  -28), iq(  97,  -83), iq(  40,  111), iq(  -5,  120)
   };

endpackage

// File: rtl/preamble_generator_if.sv
// rtl/preamble_generator_if.sv - complex-sample transmit stream towards the DAC path
interface preamble_generator_if;
   logic        tx_axis_tvalid;
   logic        tx_axis_tready;
   logic        tx_axis_tlast;
   logic [31:0] tx_axis_tdata;

   modport master (output tx_axis_tvalid, output tx_axis_tlast, output tx_axis_tdata,
                   input  tx_axis_tready);
   modport slave  (input  tx_axis_tvalid, input  tx_axis_tlast, input  tx_axis_tdata,
                   output tx_axis_tready);
endinterface

// File: rtl/preamble_rom.sv
// rtl/preamble_rom.sv - registered lookup into the STS/LTS tables, one-cycle latency
module preamble_rom
   import preamble_pkg::*;
(
   input  logic        clk_in,
   input  logic        en_in,
   input  logic        sel_lts_in,
   input  logic [5:0]  addr_in,
   output logic [31:0] data_out
);
   logic [31:0] data_q, data_d;

   always_comb begin
      data_d = data_q;
      if (en_in) begin
         data_d = sel_lts_in ? lts_rom[addr_in] : sts_rom[addr_in[3:0]];
      end
   end

   always_ff @(posedge clk_in) begin
      data_q <= data_d;
   end

   assign data_out = data_q;
endmodule

// File: rtl/preamble_generator.sv
// rtl/preamble_generator.sv - one legacy training preamble per trigger on a 20 MSPS stream
module preamble_generator
   import preamble_pkg::*;
#(
   parameter int GAP_CYCLES = 1000,
   parameter int SHIFT      = 0
) (
   input  logic                 clk_in,
   input  logic                 rst_in,
   input  logic                 start_in,
   input  logic                 repeat_in,
   output logic                 busy_out,
   output logic [15:0]          frame_count_out,
   preamble_generator_if.master tx
);
   localparam int GW        = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
   localparam int FRAME_LEN = STS_LEN + LTS_LEN;

   state_t        state_q, state_d;
   logic [7:0]    beat_q, beat_d;
   logic [8:0]    fetch_q, fetch_d;
   logic [GW-1:0] gap_q, gap_d;
   logic [15:0]   count_q, count_d;
   logic          busy_q, busy_d;
   logic          tvalid_q, tvalid_d;
   logic          tlast_q, tlast_d;
   logic [31:0]   tdata_q, tdata_d;

   logic          rom_en, rom_sel_lts;
   logic [5:0]    rom_addr, lts_k;
   logic [31:0]   rom_data;
   logic          streaming, xfer, load;

   preamble_rom u_rom (
      .clk_in     (clk_in),
      .en_in      (rom_en),
      .sel_lts_in (rom_sel_lts),
      .addr_in    (rom_addr),
      .data_out   (rom_data)
   );

   always_comb begin
      // fetch_q is the frame beat index being read from the ROM, one ahead of the output register
      rom_sel_lts = fetch_q >= 9'(STS_LEN);
      lts_k       = 6'(fetch_q - 9'(STS_LEN));
      rom_addr    = rom_sel_lts ? 6'(lts_k + 6'(GI2_LEN)) : {2'b00, fetch_q[3:0]};

      streaming = (state_q == STS) || (state_q == LTS);
      xfer      = tvalid_q && tx.tx_axis_tready;
      load      = streaming && (fetch_q <= 9'(FRAME_LEN)) && (!tvalid_q || tx.tx_axis_tready);
      rom_en    = (state_q == PRE) || load;

      state_d  = state_q;
      beat_d   = beat_q;
      fetch_d  = fetch_q;
      gap_d    = gap_q;
      count_d  = count_q;
      tvalid_d = tvalid_q;
      tlast_d  = tlast_q;
      tdata_d  = tdata_q;

      if (xfer) begin
         tvalid_d = 1'b0;
         tlast_d  = 1'b0;
      end
      if (load) begin
         tvalid_d = 1'b1;
         tlast_d  = (fetch_q == 9'(FRAME_LEN));
         tdata_d  = {asr16(rom_data[31:16], SHIFT), asr16(rom_data[15:0], SHIFT)};
         fetch_d  = fetch_q + 9'd1;
      end

      case (state_q)
         IDLE: begin
            if (start_in) begin
               state_d = PRE;
               fetch_d = '0;
               beat_d  = '0;
            end
         end
         PRE: begin
            state_d = STS;
            fetch_d = fetch_q + 9'd1;
         end
         STS: begin
            if (xfer) begin
               if (beat_q == 8'(STS_LEN - 1)) begin
                  state_d = LTS;
                  beat_d  = '0;
               end else begin
                  beat_d = beat_q + 8'd1;
               end
            end
         end
         LTS: begin
            if (xfer) begin
               if (beat_q == 8'(LTS_LEN - 1)) begin
                  count_d = count_q + 16'd1;
                  beat_d  = '0;
                  if (!repeat_in) begin
                     state_d = IDLE;
                  end else if (GAP_CYCLES == 0) begin
                     state_d = PRE;
                     fetch_d = '0;
                  end else begin
                     state_d = GAP;
                     gap_d   = '0;
                  end
               end else begin
                  beat_d = beat_q + 8'd1;
               end
            end
         end
         GAP: begin
            if (!repeat_in) begin
               state_d = IDLE;
            end else if (gap_q == GW'(GAP_CYCLES - 1)) begin
               state_d = PRE;
               fetch_d = '0;
            end else begin
               gap_d = gap_q + 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase

      busy_d = (state_d != IDLE);
   end

   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         state_q  <= IDLE;
         beat_q   <= '0;
         fetch_q  <= '0;
         gap_q    <= '0;
         count_q  <= '0;
         busy_q   <= 1'b0;
         tvalid_q <= 1'b0;
         tlast_q  <= 1'b0;
         tdata_q  <= '0;
      end else begin
         state_q  <= state_d;
         beat_q   <= beat_d;
         fetch_q  <= fetch_d;
         gap_q    <= gap_d;
         count_q  <= count_d;
         busy_q   <= busy_d;
         tvalid_q <= tvalid_d;
         tlast_q  <= tlast_d;
         tdata_q  <= tdata_d;
      end
   end

   assign busy_out          = busy_q;
   assign frame_count_out   = count_q;
   assign tx.tx_axis_tvalid = tvalid_q;
   assign tx.tx_axis_tlast  = tlast_q;
   assign tx.tx_axis_tdata  = tdata_q;
endmodule
